// File: rtl/gb_dma_ctrl.sv
// DMA engine: DMG-style OAM DMA plus an optional CGB-style general-purpose block copy.
// One byte moves every two clocks through a single-byte buffer (READ then WRITE).
module gb_dma_ctrl #(
  parameter int unsigned OAM_LEN     = 160,
  parameter int unsigned START_DELAY = 1,
  parameter bit          GP_EN       = 1'b1,
  parameter int unsigned GP_UNIT     = 16
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [2:0]  reg_sel,
  input  logic        reg_wr,
  input  logic [7:0]  reg_din,
  output logic [7:0]  reg_dout,
  output logic [15:0] adr_rd,
  output logic        rd,
  input  logic [7:0]  din_rd,
  output logic [15:0] adr_wr,
  output logic        wr,
  output logic [7:0]  dout_wr,
  output logic        oam_active,
  output logic        gp_active,
  output logic        done
);
  localparam int unsigned UNIT_SH = $clog2(GP_UNIT);
  localparam int unsigned DLY_W   = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_READ, S_WRITE} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_gp;
  logic             r_pend;
  logic             r_done;
  logic [DLY_W-1:0] r_dly;
  logic [15:0]      r_src, r_dst, r_idx, r_last;
  logic [7:0]       r_buf, r_oam_hi;
  logic [7:0]       r_gp_src_hi, r_gp_src_lo, r_gp_dst_hi, r_gp_dst_lo;

  logic       w_busy, w_gp_act, w_wr0, w_last, w_start_oam, w_start_gp;
  logic [7:0] w_oam_hi;
  logic [6:0] w_units;

  function automatic logic [7:0] f_echo(input logic [7:0] hi);
    return (hi >= 8'hE0) ? (hi & 8'hDF) : hi;
  endfunction

  assign w_busy   = (r_state != S_IDLE);
  assign w_gp_act = w_busy & r_gp;
  assign w_wr0    = reg_wr & (reg_sel == 3'd0);
  assign w_last   = (r_state == S_WRITE) & (r_idx == r_last);
  // An OAM write during GP only queues; the queued run launches from the first idle cycle.
  assign w_start_oam = (w_wr0 & ~w_gp_act) | (~w_busy & r_pend);
  assign w_start_gp  = GP_EN & reg_wr & (reg_sel == 3'd5) & ~w_busy & ~r_pend;
  assign w_oam_hi    = w_wr0 ? reg_din : r_oam_hi;
  assign w_units     = 7'((r_last - r_idx) >> UNIT_SH);

  assign rd         = (r_state == S_READ);
  assign wr         = (r_state == S_WRITE);
  assign adr_rd     = rd ? (r_src + r_idx) : '0;
  assign adr_wr     = wr ? (r_dst + r_idx) : '0;
  assign dout_wr    = wr ? r_buf : '0;
  assign oam_active = w_busy & ~r_gp;
  assign gp_active  = w_gp_act;
  assign done       = r_done;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_DELAY: if (r_dly == DLY_W'(START_DELAY - 1)) w_state_nxt = S_READ;
      S_READ:  w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = (r_idx == r_last) ? S_IDLE : S_READ;
      default: w_state_nxt = r_state;
    endcase
    if (w_start_oam || w_start_gp) w_state_nxt = (START_DELAY == 0) ? S_READ : S_DELAY;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_gp        <= 1'b0;
      r_pend      <= 1'b0;
      r_done      <= 1'b0;
      r_dly       <= '0;
      r_src       <= '0;
      r_dst       <= '0;
      r_idx       <= '0;
      r_last      <= '0;
      r_buf       <= '0;
      r_oam_hi    <= '0;
      r_gp_src_hi <= '0;
      r_gp_src_lo <= '0;
      r_gp_dst_hi <= '0;
      r_gp_dst_lo <= '0;
    end else begin
      // A restart landing on the final write suppresses the completion pulse.
      r_done <= w_last & ~w_start_oam;
      if (w_wr0) r_oam_hi <= reg_din;
      if (w_start_oam)           r_pend <= 1'b0;
      else if (w_wr0 && w_gp_act) r_pend <= 1'b1;

      if (GP_EN && reg_wr && !w_gp_act) begin
        case (reg_sel)
          3'd1:    r_gp_src_hi <= reg_din;
          3'd2:    r_gp_src_lo <= reg_din & 8'hF0;
          3'd3:    r_gp_dst_hi <= reg_din;
          3'd4:    r_gp_dst_lo <= reg_din & 8'hF0;
          default: ;
        endcase
      end

      if (w_start_oam) begin
        r_gp   <= 1'b0;
        r_src  <= {f_echo(w_oam_hi), 8'h00};
        r_dst  <= 16'hFE00;
        r_last <= 16'(OAM_LEN - 1);
        r_idx  <= '0;
        r_dly  <= '0;
      end else if (w_start_gp) begin
        r_gp   <= 1'b1;
        r_src  <= {r_gp_src_hi, r_gp_src_lo};
        r_dst  <= {r_gp_dst_hi, r_gp_dst_lo};
        r_last <= 16'(((32'(reg_din[6:0]) + 32'd1) << UNIT_SH) - 32'd1);
        r_idx  <= '0;
        r_dly  <= '0;
      end else begin
        if (r_state == S_DELAY) r_dly <= r_dly + DLY_W'(1);
        if (rd) r_buf <= din_rd;
        if (wr) r_idx <= r_idx + 16'd1;
      end
    end
  end

  always_comb begin
    reg_dout = 8'hFF;
    case (reg_sel)
      3'd0: reg_dout = r_oam_hi;
      3'd1: if (GP_EN) reg_dout = r_gp_src_hi;
      3'd2: if (GP_EN) reg_dout = r_gp_src_lo;
      3'd3: if (GP_EN) reg_dout = r_gp_dst_hi;
      3'd4: if (GP_EN) reg_dout = r_gp_dst_lo;
      3'd5: if (GP_EN && w_gp_act) reg_dout = {1'b0, w_units};
      default: reg_dout = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_gb_dma_ctrl.sv
// Self-checking bench for gb_dma_ctrl: register table, directed corner sequences and
// randomized transfers compared against a byte-level copy model over a random memory image.
module tb_gb_dma_ctrl;
  logic        clk = 1'b0;
  logic        n_reset;
  logic [2:0]  reg_sel;
  logic        reg_wr;
  logic [7:0]  reg_din, reg_dout, din_rd, dout_wr;
  logic [15:0] adr_rd, adr_wr;
  logic        rd, wr, oam_active, gp_active, done;

  gb_dma_ctrl #(.OAM_LEN(160), .START_DELAY(1), .GP_EN(1'b1), .GP_UNIT(16)) dut (
    .clk(clk), .n_reset(n_reset), .reg_sel(reg_sel), .reg_wr(reg_wr), .reg_din(reg_din),
    .reg_dout(reg_dout), .adr_rd(adr_rd), .rd(rd), .din_rd(din_rd), .adr_wr(adr_wr),
    .wr(wr), .dout_wr(dout_wr), .oam_active(oam_active), .gp_active(gp_active), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  assign din_rd = rd ? mem[adr_rd] : 8'h00;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0, oam_cyc = 0, gp_cyc = 0, viol = 0;
  logic [15:0] wa_q[$], ra_q[$];
  logic [7:0]  wd_q[$];
  logic [7:0]  rv;

  always @(negedge clk) begin
    if (n_reset) begin
      if (rd) ra_q.push_back(adr_rd);
      if (wr) begin wa_q.push_back(adr_wr); wd_q.push_back(dout_wr); end
      if (done) done_cnt++;
      if (oam_active) oam_cyc++;
      if (gp_active) gp_cyc++;
      if ((oam_active && gp_active) || (rd && wr)) viol++;
    end
  end

  typedef struct {
    logic [2:0] sel;
    logic       wr;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic [2:0] s, input logic w, input logic [7:0] d, input logic [7:0] e);
    vec_t v;
    v.sel = s; v.wr = w; v.din = d; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    repeat (4) tick();
  endtask

  task automatic reg_write(input logic [2:0] sel, input logic [7:0] d);
    reg_sel = sel; reg_din = d; reg_wr = 1'b1;
    tick();
    reg_wr = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] sel, output logic [7:0] d);
    reg_sel = sel; #1;
    d = reg_dout;
  endtask

  task automatic clear();
    done_cnt = 0; oam_cyc = 0; gp_cyc = 0;
    wa_q.delete(); wd_q.delete(); ra_q.delete();
  endtask

  task automatic wait_done(input int maxc, input string name);
    bit seen = 1'b0;
    for (int c = 0; c < maxc && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_writes(input int n, input string name);
    for (int c = 0; c < 2000 && wa_q.size() < n; c++) tick();
    chk({name, "_progress"}, 32'(wa_q.size() >= n), 32'd1);
  endtask

  // Expected copy: byte k goes from (src+k) mod 64K to (dst+k) mod 64K.
  task automatic check_xfer(input string name, input int base, input int src, input int dst,
                            input int len, input bit exact);
    int idx;
    logic [31:0] got, exp;
    if (exact) chk({name, "_count"}, 32'(wa_q.size() - base), 32'(len));
    idx = len - 1;
    for (int k = 0; k < len; k++) begin
      if (base + k >= wa_q.size()) begin idx = k; break; end
      if (wa_q[base+k] != 16'((dst + k) % 65536) || wd_q[base+k] != mem[(src + k) % 65536]) begin
        idx = k; break;
      end
    end
    exp = {8'h00, 16'((dst + idx) % 65536), mem[(src + idx) % 65536]};
    got = (base + idx < wa_q.size()) ? {8'h00, wa_q[base+idx], wd_q[base+idx]} : 32'hFFFF_FFFF;
    chk({name, "_data"}, got, exp);
  endtask

  initial begin
    int bw, br, len, src, dst;
    logic [7:0] hi, s_hi, s_lo, d_hi, d_lo, n;
    bit is_oam;

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    n_reset = 1'b0; reg_sel = 3'd0; reg_wr = 1'b0; reg_din = 8'h00;

    tbl.push_back(mk(3'd0, 1'b0, 8'h00, 8'h00));
    tbl.push_back(mk(3'd1, 1'b0, 8'h00, 8'h00));
    tbl.push_back(mk(3'd2, 1'b0, 8'h00, 8'h00));
    tbl.push_back(mk(3'd3, 1'b0, 8'h00, 8'h00));
    tbl.push_back(mk(3'd4, 1'b0, 8'h00, 8'h00));
    tbl.push_back(mk(3'd5, 1'b0, 8'h00, 8'hFF));
    tbl.push_back(mk(3'd6, 1'b0, 8'h00, 8'hFF));
    tbl.push_back(mk(3'd1, 1'b1, 8'h12, 8'h12));
    tbl.push_back(mk(3'd2, 1'b1, 8'hAB, 8'hA0));
    tbl.push_back(mk(3'd3, 1'b1, 8'hC3, 8'hC3));
    tbl.push_back(mk(3'd4, 1'b1, 8'h5F, 8'h50));
    tbl.push_back(mk(3'd2, 1'b1, 8'h0F, 8'h00));
    tbl.push_back(mk(3'd7, 1'b1, 8'h11, 8'hFF));
    tbl.push_back(mk(3'd1, 1'b0, 8'h00, 8'h12));

    repeat (3) tick();
    chk("rst_ctrl", {rd, wr, oam_active, gp_active, done}, 5'b0);
    chk("rst_addr", {adr_rd, adr_wr}, 32'h0);
    n_reset = 1'b1;
    tick();

    foreach (tbl[i]) begin
      if (tbl[i].wr) reg_write(tbl[i].sel, tbl[i].din);
      reg_read(tbl[i].sel, rv);
      chk($sformatf("vec%0d_sel%0d", i, tbl[i].sel), rv, tbl[i].exp);
      tick();
    end
    chk("vec_no_activity", {oam_active, gp_active}, 2'b00);

    // Plain OAM DMA from C000
    clear();
    reg_write(3'd0, 8'hC0);
    chk("oam1_rise", {oam_active, gp_active}, 2'b10);
    wait_done(2000, "oam1");
    chk("oam1_fall", {oam_active, gp_active}, 2'b00);
    settle();
    chk("oam1_cycles", oam_cyc, 321);
    chk("oam1_done_cnt", done_cnt, 1);
    chk("oam1_first_rd", (ra_q.size() > 0) ? 32'(ra_q[0]) : 32'hFFFF_FFFF, 32'hC000);
    chk("oam1_last_wr", (wa_q.size() > 0) ? 32'(wa_q[$]) : 32'hFFFF_FFFF, 32'hFE9F);
    check_xfer("oam1", 0, 32'hC000, 32'hFE00, 160, 1'b1);

    // OAM restart mid-run
    clear();
    reg_write(3'd0, 8'hC0);
    wait_writes(40, "restart");
    reg_write(3'd0, 8'hD0);
    bw = wa_q.size(); br = ra_q.size();
    chk("restart_active", oam_active, 1'b1);
    wait_done(2000, "restart");
    settle();
    chk("restart_first_rd", (ra_q.size() > br) ? 32'(ra_q[br]) : 32'hFFFF_FFFF, 32'hD000);
    check_xfer("restart", bw, 32'hD000, 32'hFE00, 160, 1'b1);
    chk("restart_done_cnt", done_cnt, 1);

    // GP copy 8000 -> C000, two units
    clear();
    reg_write(3'd1, 8'h80); reg_write(3'd2, 8'h00);
    reg_write(3'd3, 8'hC0); reg_write(3'd4, 8'h00);
    reg_write(3'd5, 8'h01);
    chk("gp_rise", {oam_active, gp_active}, 2'b01);
    reg_read(3'd5, rv);
    chk("gp_reg5_start", rv, 8'h01);
    wait_writes(20, "gp");
    reg_read(3'd5, rv);
    chk("gp_reg5_mid", rv, 8'h00);
    reg_write(3'd1, 8'h33);
    reg_write(3'd5, 8'h05);
    reg_read(3'd1, rv);
    chk("gp_reg1_locked", rv, 8'h80);
    wait_done(2000, "gp");
    settle();
    reg_read(3'd5, rv);
    chk("gp_reg5_end", rv, 8'hFF);
    chk("gp_cycles", gp_cyc, 65);
    chk("gp_done_cnt", done_cnt, 1);
    check_xfer("gp", 0, 32'h8000, 32'hC000, 32, 1'b1);

    // GP address wrap past FFFF on both sides
    clear();
    reg_write(3'd1, 8'hFF); reg_write(3'd2, 8'hF8);
    reg_write(3'd3, 8'hFF); reg_write(3'd4, 8'hF0);
    reg_write(3'd5, 8'h01);
    wait_done(2000, "wrap");
    settle();
    chk("wrap_first_rd", (ra_q.size() > 0) ? 32'(ra_q[0]) : 32'hFFFF_FFFF, 32'hFFF0);
    chk("wrap_rd16", (ra_q.size() > 16) ? 32'(ra_q[16]) : 32'hFFFF_FFFF, 32'h0000);
    check_xfer("wrap", 0, 32'hFFF0, 32'hFFF0, 32, 1'b1);

    // Echo-region source
    clear();
    reg_write(3'd0, 8'hF0);
    wait_done(2000, "echo");
    settle();
    reg_read(3'd0, rv);
    chk("echo_reg0", rv, 8'hF0);
    chk("echo_first_rd", (ra_q.size() > 0) ? 32'(ra_q[0]) : 32'hFFFF_FFFF, 32'hD000);
    check_xfer("echo", 0, 32'hD000, 32'hFE00, 160, 1'b1);

    // OAM request during GP queues, latest value wins
    clear();
    reg_write(3'd1, 8'h40); reg_write(3'd2, 8'h00);
    reg_write(3'd3, 8'h80); reg_write(3'd4, 8'h00);
    reg_write(3'd5, 8'h00);
    reg_write(3'd0, 8'hE5);
    reg_write(3'd0, 8'hC1);
    chk("queue_gp_owns", {oam_active, gp_active}, 2'b01);
    reg_read(3'd0, rv);
    chk("queue_reg0", rv, 8'hC1);
    wait_done(2000, "queue_gp");
    chk("queue_gap", {oam_active, gp_active}, 2'b00);
    @(negedge clk);
    chk("queue_oam_start", {oam_active, gp_active}, 2'b10);
    wait_done(2000, "queue_oam");
    settle();
    chk("queue_done_cnt", done_cnt, 2);
    check_xfer("queue_gp", 0, 32'h4000, 32'h8000, 16, 1'b0);
    check_xfer("queue_oam", 16, 32'hC100, 32'hFE00, 160, 1'b1);

    // OAM in progress blocks a GP start
    clear();
    reg_write(3'd0, 8'h12);
    reg_write(3'd5, 8'h02);
    chk("block_gp", {oam_active, gp_active}, 2'b10);
    reg_read(3'd5, rv);
    chk("block_reg5", rv, 8'hFF);
    wait_done(2000, "block");
    settle();
    chk("block_done_cnt", done_cnt, 1);
    check_xfer("block", 0, 32'h1200, 32'hFE00, 160, 1'b1);

    // Asynchronous reset mid-transfer
    clear();
    reg_write(3'd0, 8'hC0);
    wait_writes(10, "arst");
    chk("arst_pre", oam_active, 1'b1);
    #2 n_reset = 1'b0;
    #1;
    chk("arst_outputs", {rd, wr, oam_active, gp_active, done}, 5'b0);
    reg_read(3'd0, rv);
    chk("arst_reg0", rv, 8'h00);
    reg_read(3'd1, rv);
    chk("arst_reg1", rv, 8'h00);
    tick();
    bw = wa_q.size();
    n_reset = 1'b1;
    repeat (400) tick();
    chk("arst_no_done", done_cnt, 0);
    chk("arst_no_wr", wa_q.size(), bw);

    // Randomized transfers against the copy model
    for (int t = 0; t < 16; t++) begin
      clear();
      is_oam = 1'($urandom_range(0, 1));
      if (is_oam) begin
        hi = 8'($urandom);
        reg_write(3'd0, hi);
        src = (hi >= 8'hE0) ? (int'(hi) - 32) * 256 : int'(hi) * 256;
        dst = 32'hFE00;
        len = 160;
      end else begin
        s_hi = 8'($urandom); s_lo = 8'($urandom);
        d_hi = 8'($urandom); d_lo = 8'($urandom);
        n = {1'($urandom), 5'b0, 2'($urandom)};
        reg_write(3'd1, s_hi); reg_write(3'd2, s_lo);
        reg_write(3'd3, d_hi); reg_write(3'd4, d_lo);
        reg_write(3'd5, n);
        src = int'(s_hi) * 256 + (int'(s_lo) / 16) * 16;
        dst = int'(d_hi) * 256 + (int'(d_lo) / 16) * 16;
        len = ((int'(n) % 128) + 1) * 16;
      end
      wait_done(2000, $sformatf("rnd%0d", t));
      settle();
      check_xfer($sformatf("rnd%0d", t), 0, src, dst, len, 1'b1);
      chk($sformatf("rnd%0d_cycles", t), is_oam ? oam_cyc : gp_cyc, 1 + 2 * len);
      chk($sformatf("rnd%0d_done_cnt", t), done_cnt, 1);
    end

    chk("exclusive_outputs", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
